// File: rtl/uart_pkg.sv
// Shared definitions for the 8N1 UART: state encodings, frame width and
// baud-rate divider helper used by both the receiver and transmitter.
package uart_pkg;

    localparam int DATA_BITS = 8;

    // The transmitter reuses IDLE..STOP; BREAK only exists on the receive side.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } uart_state_t;

    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input; the reset value is
// chosen per signal so an idle line does not look active after reset.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    // NOTE: non-blocking assignments keep the two stages as two distinct flops;
    // blocking here would collapse the chain into a single register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 serial receiver: synchronizes rx, locks onto each start bit, samples
// every bit at its midpoint and reports bytes or framing errors as pulses.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 115200
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CTR_WIDTH    = $clog2(CLKS_PER_BIT);

    localparam logic [CTR_WIDTH-1:0] HALF_LAST = CTR_WIDTH'(HALF_BIT - 1);
    localparam logic [CTR_WIDTH-1:0] BIT_LAST  = CTR_WIDTH'(CLKS_PER_BIT - 1);
    localparam logic [2:0]           IDX_LAST  = 3'(DATA_BITS - 1);

    logic                 rx_s;
    uart_state_t          state;
    logic [CTR_WIDTH-1:0] clk_ctr;
    logic [2:0]           bit_idx;
    logic [DATA_BITS-1:0] shift_reg;

    sync_2ff #(.RST_VAL(1'b1)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rx),
        .q     (rx_s)
    );

    assign busy = (state != IDLE);

    // NOTE: the data and shift registers are reset along with control state so
    // the byte output has a defined value before the first frame arrives.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            clk_ctr   <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            data      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            valid     <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state   <= START;
                        clk_ctr <= '0;
                    end
                end
                START: begin
                    // Re-check the line at mid start bit to reject short glitches.
                    if (clk_ctr == HALF_LAST) begin
                        clk_ctr <= '0;
                        if (!rx_s) begin
                            state   <= DATA;
                            bit_idx <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        clk_ctr <= clk_ctr + 1'b1;
                    end
                end
                DATA: begin
                    if (clk_ctr == BIT_LAST) begin
                        shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
                        clk_ctr   <= '0;
                        if (bit_idx == IDX_LAST) begin
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        clk_ctr <= clk_ctr + 1'b1;
                    end
                end
                STOP: begin
                    // Leaving at mid stop bit lets an immediately following start bit be caught.
                    if (clk_ctr == BIT_LAST) begin
                        clk_ctr <= '0;
                        if (rx_s) begin
                            data  <= shift_reg;
                            valid <= 1'b1;
                            state <= IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= BREAK;
                        end
                    end else begin
                        clk_ctr <= clk_ctr + 1'b1;
                    end
                end
                BREAK: begin
                    if (rx_s) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at 16 clocks per bit: directed scenarios
// plus a randomized frame stream checked against a byte-level expectation queue.
module tb_uart_rx;

    localparam int CPB = 16;

    typedef struct {
        bit         is_err;
        logic [7:0] d;
        int         cyc;
    } event_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       busy;

    int         tests_run = 0;
    int         tests_failed = 0;
    int         cycle_cnt = 0;
    int         overlap_cnt = 0;
    logic [7:0] last_good = 8'h00;
    event_t     ev_q[$];

    uart_rx #(.CLK_FREQ(16), .BAUD(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .data      (data),
        .valid     (valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    // Log every output pulse with the cycle it was observed in.
    always @(negedge clk) begin
        if (valid) ev_q.push_back('{is_err: 1'b0, d: data, cyc: cycle_cnt});
        if (frame_err) ev_q.push_back('{is_err: 1'b1, d: data, cyc: cycle_cnt});
        if (valid && frame_err) overlap_cnt <= overlap_cnt + 1;
    end

    task automatic drive_bit(input logic b);
        rx = b;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop);
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_one_valid(input string name, input logic [7:0] exp);
        tests_run++;
        if (ev_q.size() !== 1) begin
            tests_failed++;
            $display("FAIL %s: pulse count got %0d want 1", name, ev_q.size());
        end else if (ev_q[0].is_err !== 1'b0 || ev_q[0].d !== exp) begin
            tests_failed++;
            $display("FAIL %s: got err=%0b data=%h want err=0 data=%h",
                     name, ev_q[0].is_err, ev_q[0].d, exp);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        rx    = 1'b1;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({data, valid, frame_err, busy} !== 11'h0) begin
            tests_failed++;
            $display("FAIL reset: got data=%h valid=%b frame_err=%b busy=%b want all 0",
                     data, valid, frame_err, busy);
        end
        rst_n = 1'b1;
        idle(4);
        tests_run++;
        if (ev_q.size() !== 0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_idle: got events=%0d busy=%b want 0 0", ev_q.size(), busy);
        end
        ev_q.delete();
    endtask

    task automatic test_ideal();
        int t0;
        int lat;
        ev_q.delete();
        t0 = cycle_cnt;
        send_frame(8'h55, 1'b1);
        idle(4);
        expect_one_valid("ideal_55", 8'h55);
        if (ev_q.size() == 1) begin
            lat = ev_q[0].cyc - t0;
            tests_run++;
            if (lat < 155 || lat > 157) begin
                tests_failed++;
                $display("FAIL ideal_latency: got %0d clocks want 156 +/-1", lat);
            end
        end
        tests_run++;
        if (data !== 8'h55) begin
            tests_failed++;
            $display("FAIL ideal_hold: data got %h want 55", data);
        end
        last_good = 8'h55;
    endtask

    task automatic test_back_to_back();
        ev_q.delete();
        send_frame(8'hA3, 1'b1);
        send_frame(8'h0F, 1'b1);
        idle(4);
        tests_run++;
        if (ev_q.size() !== 2) begin
            tests_failed++;
            $display("FAIL b2b_count: got %0d pulses want 2", ev_q.size());
        end else begin
            tests_run++;
            if (ev_q[0].is_err || ev_q[1].is_err || ev_q[0].d !== 8'hA3 || ev_q[1].d !== 8'h0F) begin
                tests_failed++;
                $display("FAIL b2b_data: got %h/%h err %0b/%0b want A3/0F err 0/0",
                         ev_q[0].d, ev_q[1].d, ev_q[0].is_err, ev_q[1].is_err);
            end
            tests_run++;
            if (ev_q[1].cyc - ev_q[0].cyc !== 160) begin
                tests_failed++;
                $display("FAIL b2b_spacing: got %0d clocks want 160", ev_q[1].cyc - ev_q[0].cyc);
            end
        end
        last_good = 8'h0F;
    endtask

    task automatic test_glitch();
        bit saw_busy;
        saw_busy = 1'b0;
        ev_q.delete();
        rx = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (i == 5) rx = 1'b1;
            @(negedge clk);
            if (busy) saw_busy = 1'b1;
        end
        tests_run++;
        if (saw_busy !== 1'b1 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL glitch_busy: got saw_busy=%0b busy_after_12=%b want 1 0", saw_busy, busy);
        end
        idle(40);
        tests_run++;
        if (ev_q.size() !== 0) begin
            tests_failed++;
            $display("FAIL glitch_pulses: got %0d pulses want 0", ev_q.size());
        end
    endtask

    task automatic test_frame_err();
        ev_q.delete();
        send_frame(8'h3C, 1'b0);
        rx = 1'b0;
        repeat (100) @(negedge clk);
        tests_run++;
        if (busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL ferr_break_busy: got busy=%b want 1 while line held low", busy);
        end
        idle(20);
        tests_run++;
        if (ev_q.size() !== 1 || ev_q[0].is_err !== 1'b1) begin
            tests_failed++;
            $display("FAIL ferr_pulse: got %0d events (first err=%0b) want exactly one frame_err",
                     ev_q.size(), ev_q.size() > 0 ? ev_q[0].is_err : 1'b0);
        end
        tests_run++;
        if (data !== last_good || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL ferr_hold: got data=%h busy=%b want data=%h busy=0", data, busy, last_good);
        end
        ev_q.delete();
        send_frame(8'h81, 1'b1);
        idle(4);
        expect_one_valid("ferr_recover_81", 8'h81);
        last_good = 8'h81;
    endtask

    task automatic test_reset_mid();
        ev_q.delete();
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b1);
        rx = 1'b1;
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        tests_run++;
        if ({data, valid, frame_err, busy} !== 11'h0) begin
            tests_failed++;
            $display("FAIL midreset_outputs: got data=%h valid=%b frame_err=%b busy=%b want all 0",
                     data, valid, frame_err, busy);
        end
        rst_n = 1'b1;
        repeat (7) @(negedge clk);
        for (int i = 5; i < 8; i++) drive_bit(1'b1);
        drive_bit(1'b1);
        idle(20);
        tests_run++;
        if (ev_q.size() !== 0) begin
            tests_failed++;
            $display("FAIL midreset_pulses: got %0d pulses want 0", ev_q.size());
        end
        last_good = 8'h00;
        ev_q.delete();
        send_frame(8'h12, 1'b1);
        idle(4);
        expect_one_valid("midreset_next_12", 8'h12);
        last_good = 8'h12;
    endtask

    // Plays frames like a remote transmitter and compares the pulse log to the
    // expected sequence; bad_every=0 means all stop bits are good.
    task automatic run_stream(input string name, input logic [7:0] bytes[$], input int bad_every);
        event_t exp_q[$];
        logic   bad;
        ev_q.delete();
        foreach (bytes[i]) begin
            bad = (bad_every != 0) && ($urandom_range(bad_every - 1, 0) == 0);
            send_frame(bytes[i], !bad);
            if (bad) begin
                exp_q.push_back('{is_err: 1'b1, d: last_good, cyc: 0});
                rx = 1'b0;
                repeat ($urandom_range(30, 0)) @(negedge clk);
                idle($urandom_range(20, 2));
            end else begin
                exp_q.push_back('{is_err: 1'b0, d: bytes[i], cyc: 0});
                last_good = bytes[i];
                if (bad_every != 0) idle($urandom_range(20, 0));
            end
        end
        idle(20);
        tests_run++;
        if (ev_q.size() !== exp_q.size()) begin
            tests_failed++;
            $display("FAIL %s_count: got %0d events want %0d", name, ev_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                tests_run++;
                if (ev_q[i].is_err !== exp_q[i].is_err ||
                    (!exp_q[i].is_err && ev_q[i].d !== exp_q[i].d)) begin
                    tests_failed++;
                    $display("FAIL %s_event%0d: got err=%0b data=%h want err=%0b data=%h",
                             name, i, ev_q[i].is_err, ev_q[i].d, exp_q[i].is_err, exp_q[i].d);
                end
            end
        end
        tests_run++;
        if (data !== last_good) begin
            tests_failed++;
            $display("FAIL %s_final_data: got %h want %h", name, data, last_good);
        end
    endtask

    task automatic test_loopback();
        logic [7:0] bytes[$];
        bytes = '{8'h00, 8'hFF, 8'h5A};
        run_stream("loopback", bytes, 0);
    endtask

    task automatic test_random();
        logic [7:0] bytes[$];
        for (int i = 0; i < 24; i++) bytes.push_back(8'($urandom));
        run_stream("random", bytes, 6);
        tests_run++;
        if (overlap_cnt !== 0) begin
            tests_failed++;
            $display("FAIL overlap: valid and frame_err high together %0d times want 0", overlap_cnt);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_ideal();
        test_back_to_back();
        test_glitch();
        test_frame_err();
        test_reset_mid();
        test_loopback();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
